// File: rtl/load_control_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | load_control_pkg: opcodes, instruction fields, AXI constants, FSM codes |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package load_control_pkg;

  localparam logic [2:0] OP_WB     = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_SETPTR = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 29;
  localparam int LEN_MSB  = 28;
  localparam int LEN_LSB  = 26;
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 0;

  localparam logic [2:0] SIZE_4B         = 3'b010;
  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam int         RESP_SLVERR_BIT = 1;
  localparam logic [3:0] LOAD_ARID       = 4'b0010;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ADDR = 4'b0010,
    ST_DATA = 4'b0100,
    ST_RESP = 4'b1000
  } load_state_e;

  // Each len step adds 32 beats, so ARLEN is always 32*(len+1)-1.
  function automatic logic [7:0] burst_arlen(input logic [2:0] len);
    return {len, 5'b11111};
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | load_control: AXI4 read master streaming load bursts into the buffer   |
// | Optional macro LOAD_RLAST_CHECK_EN: beat counter and RLAST checking.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module load_control
  import load_control_pkg::*;
#(
  parameter logic [3:0] RD_BASE_ADDR      = 4'h0,
  parameter int         AXI_WIDTH_ID      = 4,
  parameter int         AXI_WIDTH_AD      = 32,
  parameter int         AXI_WIDTH_DA      = 32,
  parameter int         BUFFER_ADDR_WIDTH = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         m_axi_memory_bus_ARVALID,
  input  logic                         m_axi_memory_bus_ARREADY,
  output logic [AXI_WIDTH_AD-1:0]      m_axi_memory_bus_ARADDR,
  output logic [AXI_WIDTH_ID-1:0]      m_axi_memory_bus_ARID,
  output logic [7:0]                   m_axi_memory_bus_ARLEN,
  output logic [2:0]                   m_axi_memory_bus_ARSIZE,
  output logic [1:0]                   m_axi_memory_bus_ARBURST,
  input  logic                         m_axi_memory_bus_RVALID,
  output logic                         m_axi_memory_bus_RREADY,
  input  logic [AXI_WIDTH_DA-1:0]      m_axi_memory_bus_RDATA,
  input  logic [1:0]                   m_axi_memory_bus_RRESP,
  input  logic                         m_axi_memory_bus_RLAST,
  input  logic                         i_load_instruction_fifo_empty,
  input  logic [31:0]                  i_load_instruction_data,
  output logic                         o_load_instruction_fifo_rd_en,
  output logic                         o_load_idle,
  output logic                         o_buffer_wr_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] o_buffer_wr_addr,
  output logic [31:0]                  o_buffer_wr_data,
  output logic                         o_load_protocol_err
);

  load_state_e                  state_q, state_d;
  logic                         arvalid_q, arvalid_d;
  logic                         rready_q, rready_d;
  logic [25:0]                  addr_q, addr_d;
  logic [2:0]                   len_q, len_d;
  logic [BUFFER_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUFFER_ADDR_WIDTH-1:0] burst_start_q, burst_start_d;
  logic                         err_q, err_d;

  logic       rd_en;
  logic       beat;
  logic       burst_end;
  logic [2:0] opcode;
  logic [7:0] arlen;
  logic       unused_rresp;

`ifdef LOAD_RLAST_CHECK_EN
  logic [8:0] beat_cnt_q, beat_cnt_d;
  logic       proto_err_q, proto_err_d;
  logic       last_expected;
`endif

  assign unused_rresp = m_axi_memory_bus_RRESP[0];

  always_comb begin
    opcode = i_load_instruction_data[OPC_MSB:OPC_LSB];
    arlen  = burst_arlen(len_q);
    rd_en  = (state_q == ST_IDLE) && !i_load_instruction_fifo_empty;
    beat   = (state_q == ST_DATA) && m_axi_memory_bus_RVALID && rready_q;
`ifdef LOAD_RLAST_CHECK_EN
    // A missing RLAST still terminates the burst at the advertised length.
    last_expected = (beat_cnt_q == {1'b0, arlen});
    burst_end     = m_axi_memory_bus_RLAST || last_expected;
`else
    burst_end     = m_axi_memory_bus_RLAST;
`endif

    state_d       = state_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    addr_d        = addr_q;
    len_d         = len_q;
    wr_ptr_d      = wr_ptr_q;
    burst_start_d = burst_start_q;
    err_d         = err_q;
`ifdef LOAD_RLAST_CHECK_EN
    beat_cnt_d    = beat_cnt_q;
    proto_err_d   = proto_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rd_en) begin
          if (opcode == OP_LOAD) begin
            addr_d        = i_load_instruction_data[ADDR_MSB:ADDR_LSB];
            len_d         = i_load_instruction_data[LEN_MSB:LEN_LSB];
            burst_start_d = wr_ptr_q;
            arvalid_d     = 1'b1;
            state_d       = ST_ADDR;
          end else if (opcode == OP_SETPTR) begin
            wr_ptr_d = i_load_instruction_data[BUFFER_ADDR_WIDTH-1:0];
          end
        end
      end
      ST_ADDR: begin
        if (m_axi_memory_bus_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DATA;
`ifdef LOAD_RLAST_CHECK_EN
          beat_cnt_d = '0;
`endif
        end
      end
      ST_DATA: begin
        if (beat) begin
          wr_ptr_d = wr_ptr_q + BUFFER_ADDR_WIDTH'(1);
          if (m_axi_memory_bus_RRESP[RESP_SLVERR_BIT]) begin
            err_d = 1'b1;
          end
`ifdef LOAD_RLAST_CHECK_EN
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (m_axi_memory_bus_RLAST != last_expected) begin
            proto_err_d = 1'b1;
          end
`endif
          if (burst_end) begin
            rready_d = 1'b0;
            state_d  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        // Any errored beat replays the whole burst into the same buffer window.
        if (err_q) begin
          wr_ptr_d  = burst_start_q;
          arvalid_d = 1'b1;
          err_d     = 1'b0;
          state_d   = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      wr_ptr_q      <= '0;
      burst_start_q <= '0;
      err_q         <= 1'b0;
`ifdef LOAD_RLAST_CHECK_EN
      beat_cnt_q    <= '0;
      proto_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      wr_ptr_q      <= wr_ptr_d;
      burst_start_q <= burst_start_d;
      err_q         <= err_d;
`ifdef LOAD_RLAST_CHECK_EN
      beat_cnt_q    <= beat_cnt_d;
      proto_err_q   <= proto_err_d;
`endif
    end
  end

  assign m_axi_memory_bus_ARVALID = arvalid_q;
  assign m_axi_memory_bus_ARADDR  = AXI_WIDTH_AD'({RD_BASE_ADDR, addr_q, 2'b00});
  assign m_axi_memory_bus_ARID    = AXI_WIDTH_ID'(LOAD_ARID);
  assign m_axi_memory_bus_ARLEN   = arlen;
  assign m_axi_memory_bus_ARSIZE  = SIZE_4B;
  assign m_axi_memory_bus_ARBURST = BURST_INCR;
  assign m_axi_memory_bus_RREADY  = rready_q;

  assign o_load_instruction_fifo_rd_en = rd_en;
  assign o_load_idle                   = (state_q == ST_IDLE);
  assign o_buffer_wr_en                = beat;
  assign o_buffer_wr_addr              = wr_ptr_q;
  assign o_buffer_wr_data              = 32'(m_axi_memory_bus_RDATA);

`ifdef LOAD_RLAST_CHECK_EN
  assign o_load_protocol_err = proto_err_q;
`else
  assign o_load_protocol_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_control.sv
`default_nettype none
// Bench for load_control: instruction FIFO + AXI read slave models, buffer scoreboard.
module tb_load_control;

  localparam int BW    = 15;
  localparam int DEPTH = 1 << BW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready, rlast = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        fifo_empty = 1'b1, rd_en, idle, wr_en, perr;
  logic [31:0] fifo_data = '0, wr_data;
  logic [BW-1:0] wr_addr;

  always #5 clk = ~clk;

  load_control dut (
    .clk(clk), .rst_n(rst_n),
    .m_axi_memory_bus_ARVALID(arvalid), .m_axi_memory_bus_ARREADY(arready),
    .m_axi_memory_bus_ARADDR(araddr), .m_axi_memory_bus_ARID(arid),
    .m_axi_memory_bus_ARLEN(arlen), .m_axi_memory_bus_ARSIZE(arsize),
    .m_axi_memory_bus_ARBURST(arburst), .m_axi_memory_bus_RVALID(rvalid),
    .m_axi_memory_bus_RREADY(rready), .m_axi_memory_bus_RDATA(rdata),
    .m_axi_memory_bus_RRESP(rresp), .m_axi_memory_bus_RLAST(rlast),
    .i_load_instruction_fifo_empty(fifo_empty), .i_load_instruction_data(fifo_data),
    .o_load_instruction_fifo_rd_en(rd_en), .o_load_idle(idle),
    .o_buffer_wr_en(wr_en), .o_buffer_wr_addr(wr_addr), .o_buffer_wr_data(wr_data),
    .o_load_protocol_err(perr)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int unsigned seed;

  logic [31:0] ifq[$];

  // Slave behaviour knobs
  int ar_delay = 0, gap_pct = 0, err_beat = -1, rlast_at = -1;
  // Slave state
  bit sl_active = 0;
  int sl_beat = 0, sl_nbeats = 0, sl_attempt = 0, ar_wait = 0;
  int unsigned sl_word = 0;

  // Values seen by the upcoming rising edge, captured mid-cycle
  bit s_live = 0, s_rd_en = 0, s_ar_hs = 0, s_arvalid = 0, s_r_hs = 0, s_rlast = 0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  bit prev_arvalid = 0;
  logic [31:0] ar_hold_addr = '0;
  logic [7:0]  ar_hold_len = '0;

  int cyc = 0;
  int pop_cyc[$], ar_rise_cyc[$], ar_wait_log[$];
  logic [31:0]   ar_addr_log[$];
  logic [7:0]    ar_len_log[$];
  logic [BW-1:0] wr_addr_log[$];
  logic [31:0]   wr_data_log[$];
  int bad_cnt = 0, ar_unstable = 0;
  logic [31:0] obs_buf [DEPTH];

  int m_ptr = 0;   // reference write pointer

  function automatic logic [31:0] mem_data(input int unsigned word, input int unsigned attempt);
    return (word * 32'h9E3779B1) ^ (attempt * 32'h5BD1E995) ^ seed;
  endfunction

  function automatic logic [31:0] mk_load(input int len, input int unsigned word);
    return {3'b001, 3'(len), 26'(word)};
  endfunction

  function automatic logic [31:0] mk_setptr(input int ptr);
    return {3'b010, 29'(ptr)};
  endfunction

  // Instruction FIFO and AXI read slave, one update per cycle
  always begin
    @(negedge clk);
    cyc++;
    if (s_live) begin
      if (s_rd_en) void'(ifq.pop_front());
      if (s_ar_hs) begin
        sl_active  = 1;
        sl_beat    = 0;
        sl_word    = s_araddr >> 2;
        sl_nbeats  = int'(s_arlen) + 1;
        sl_attempt = ar_addr_log.size() - 1;
        ar_wait    = 0;
      end else if (s_arvalid) begin
        ar_wait++;
      end
      if (s_r_hs) begin
        if (s_rlast) sl_active = 0;
        sl_beat++;
        rvalid = 1'b0;
      end
    end
    arready = (ar_wait >= ar_delay);
    if (!sl_active) begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
    end else if (!rvalid && int'($urandom_range(0, 99)) >= gap_pct) begin
      rvalid = 1'b1;
      rdata  = mem_data(sl_word + sl_beat, sl_attempt);
      rresp  = (sl_attempt == 0 && sl_beat == err_beat) ? 2'b10 : 2'b00;
      rlast  = (sl_beat == ((rlast_at >= 0) ? rlast_at : sl_nbeats - 1));
    end
    fifo_empty = (ifq.size() == 0);
    fifo_data  = fifo_empty ? $urandom : ifq[0];
    #1;
    s_live    = rst_n;
    s_rd_en   = rd_en;
    s_arvalid = arvalid;
    s_ar_hs   = arvalid && arready;
    s_araddr  = araddr;
    s_arlen   = arlen;
    s_r_hs    = rvalid && rready;
    s_rlast   = rlast;
    if (rst_n) begin
      if (rd_en) pop_cyc.push_back(cyc);
      if (arvalid && !prev_arvalid) ar_rise_cyc.push_back(cyc);
      if (arvalid && prev_arvalid && (araddr !== ar_hold_addr || arlen !== ar_hold_len))
        ar_unstable++;
      if (s_ar_hs) begin
        ar_addr_log.push_back(araddr);
        ar_len_log.push_back(arlen);
        ar_wait_log.push_back(ar_wait);
      end
      if (wr_en) begin
        wr_addr_log.push_back(wr_addr);
        wr_data_log.push_back(wr_data);
        obs_buf[wr_addr] = wr_data;
      end
      if (wr_en !== s_r_hs) bad_cnt++;
      if (rready && arvalid) bad_cnt++;
    end
    prev_arvalid = arvalid;
    ar_hold_addr = araddr;
    ar_hold_len  = arlen;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    ar_rise_cyc.delete();
    ar_wait_log.delete();
    ar_addr_log.delete();
    ar_len_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    bad_cnt     = 0;
    ar_unstable = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    bit done;
    n    = 0;
    done = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      #2;
      n++;
      done = (ifq.size() == 0) && idle && !sl_active && !s_rd_en;
    end
    chk({tag, "_timeout"}, done, 1'b1);
  endtask

  // Reference: each attempt writes nwr words from ptr; the buffer ends with the last attempt.
  task automatic check_load(input string tag, input int ptr, input int unsigned word,
                            input int len, input int nwr, input int attempts, input bit exp_perr);
    int k;
    chk({tag, "_nwr"}, wr_addr_log.size(), nwr * attempts);
    chk({tag, "_nar"}, ar_addr_log.size(), attempts);
    for (int a = 0; a < attempts; a++) begin
      if (a < ar_addr_log.size()) begin
        chk({tag, "_araddr"}, ar_addr_log[a], {4'h0, 26'(word), 2'b00});
        chk({tag, "_arlen"}, ar_len_log[a], 32 * (len + 1) - 1);
      end
      for (int i = 0; i < nwr; i++) begin
        k = a * nwr + i;
        if (k < wr_addr_log.size()) begin
          chk({tag, "_wr_addr"}, wr_addr_log[k], (ptr + i) % DEPTH);
          chk({tag, "_wr_data"}, wr_data_log[k], mem_data(word + i, a));
        end
      end
    end
    for (int i = 0; i < nwr; i++)
      chk({tag, "_buf"}, obs_buf[(ptr + i) % DEPTH], mem_data(word + i, attempts - 1));
    chk({tag, "_gap_wr"}, bad_cnt, 0);
    chk({tag, "_ar_stable"}, ar_unstable, 0);
    chk({tag, "_idle"}, idle, 1'b1);
    chk({tag, "_perr"}, perr, exp_perr);
    m_ptr = (ptr + nwr) % DEPTH;
  endtask

  initial begin
    int unsigned w;
    bit exp_perr_final;
    seed = $urandom;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_perr", perr, 1'b0);
    chk("arid", arid, 4'b0010);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;

    // 1: SETPTR then a single 32-beat load, slave always ready
    clear_logs();
    ar_delay = 0; gap_pct = 0;
    ifq.push_back(mk_setptr(32'h100));
    ifq.push_back(mk_load(0, 26'h40));
    wait_idle("t1");
    check_load("t1", 32'h100, 32'h40, 0, 32, 1, 1'b0);
    chk("t1_pop_to_ar", (ar_rise_cyc.size() > 0 && pop_cyc.size() > 1) ?
        ar_rise_cyc[0] - pop_cyc[1] : -1, 1);

    // 2: 256-beat load, AR held off 5 cycles, random R gaps
    clear_logs();
    ar_delay = 5; gap_pct = 40;
    w = $urandom & 32'h03FF_FFFF;
    ifq.push_back(mk_load(7, w));
    wait_idle("t2");
    check_load("t2", m_ptr, w, 7, 256, 1, 1'b0);
    chk("t2_ar_wait", ar_wait_log.size() > 0 ? ar_wait_log[0] : -1, 5);

    // 3: SLVERR on beat 10 forces a full replay from burst start
    clear_logs();
    ar_delay = $urandom_range(0, 2); gap_pct = 20; err_beat = 10;
    w = $urandom & 32'h03FF_FFFF;
    ifq.push_back(mk_load(0, w));
    wait_idle("t3");
    check_load("t3", m_ptr, w, 0, 32, 2, 1'b0);
    err_beat = -1;

    // 4: buffer pointer wraps at the top of the address space
    clear_logs();
    ar_delay = 0; gap_pct = 10;
    w = $urandom & 32'h03FF_FFFF;
    ifq.push_back(mk_setptr(32'h7FF0));
    ifq.push_back(mk_load(0, w));
    wait_idle("t4");
    check_load("t4", 32'h7FF0, w, 0, 32, 1, 1'b0);

    // 5: SETPTR, unknown opcode, LOAD popped on consecutive cycles
    clear_logs();
    gap_pct = 0;
    w = $urandom & 32'h03FF_FFFF;
    ifq.push_back(mk_setptr(32'h200));
    ifq.push_back({3'b111, 29'($urandom)});
    ifq.push_back(mk_load(1, w));
    wait_idle("t5");
    check_load("t5", 32'h200, w, 1, 64, 1, 1'b0);
    chk("t5_npop", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3 && ar_rise_cyc.size() > 0) begin
      chk("t5_pop1", pop_cyc[1] - pop_cyc[0], 1);
      chk("t5_pop2", pop_cyc[2] - pop_cyc[0], 2);
      chk("t5_ar4th", ar_rise_cyc[0] - pop_cyc[0], 3);
    end

    // 6: early RLAST on beat 20
    clear_logs();
    rlast_at = 20; gap_pct = 15;
    w = $urandom & 32'h03FF_FFFF;
`ifdef LOAD_RLAST_CHECK_EN
    exp_perr_final = 1'b1;
`else
    exp_perr_final = 1'b0;
`endif
    ifq.push_back(mk_load(0, w));
    wait_idle("t6");
    check_load("t6", m_ptr, w, 0, 21, 1, exp_perr_final);
    rlast_at = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_control.md
Name: load_control

Overview:
- AXI4 read master that mirrors the store path: pops load instructions, issues one INCR read burst per instruction, and streams the R beats into the on-chip activation/weight buffer.
- Sits between the load instruction FIFO and the memory bus (AR/R channels) on the load side of the accelerator.
- Also owns the buffer write pointer, which is set by a dedicated instruction.

Parameters:
- RD_BASE_ADDR, 4'h0: upper 4 bits of ARADDR.
- AXI_WIDTH_ID, 4: ARID/RID width.
- AXI_WIDTH_AD, 32: address width.
- AXI_WIDTH_DA, 32: data width. Must stay 32.
- BUFFER_ADDR_WIDTH, 15: buffer word-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- m_axi_memory_bus_ARVALID  out  1  read address valid
- m_axi_memory_bus_ARREADY  in  1  read address ready
- m_axi_memory_bus_ARADDR  out  AXI_WIDTH_AD  {RD_BASE_ADDR, addr_reg[25:0], 2'b00}
- m_axi_memory_bus_ARID  out  AXI_WIDTH_ID  constant 4'b0010
- m_axi_memory_bus_ARLEN  out  8  {len_reg[2:0], 5'b11111}
- m_axi_memory_bus_ARSIZE / ARBURST  out  3/2  constants 3'b010 / 2'b01
- m_axi_memory_bus_RVALID  in  1  read data valid
- m_axi_memory_bus_RREADY  out  1  read data ready
- m_axi_memory_bus_RDATA  in  AXI_WIDTH_DA  read data
- m_axi_memory_bus_RRESP  in  2  read response
- m_axi_memory_bus_RLAST  in  1  last beat of burst
- i_load_instruction_fifo_empty  in  1  instruction FIFO empty
- i_load_instruction_data  in  32  instruction word
- o_load_instruction_fifo_rd_en  out  1  instruction pop (combinational)
- o_load_idle  out  1  high when state is IDLE
- o_buffer_wr_en  out  1  buffer write strobe
- o_buffer_wr_addr  out  BUFFER_ADDR_WIDTH  buffer write address
- o_buffer_wr_data  out  32  buffer write data
- o_load_protocol_err  out  1  sticky; only driven when the optional feature is compiled in, tied 0 otherwise

Interface facts (already decided):
- One clock, clk.
- Reset rst_n is synchronous and active-low.

Behaviour:
- **Reset:** state IDLE; ARVALID=0, RREADY=0, addr_reg=0, len_reg=0, wr_ptr=0, burst_start=0, err_sticky=0, o_load_protocol_err=0.
- **Instruction decode:** opcode is [31:29].
  - 3'b001 = LOAD: len [28:26], word address [25:0].
  - 3'b010 = SETPTR: wr_ptr <= [BUFFER_ADDR_WIDTH-1:0].
  - Any other opcode: popped and discarded.
- **States:** IDLE, ADDR, DATA, RESP.
- **IDLE**
  - If FIFO not empty: rd_en=1 for exactly that cycle.
  - LOAD: latch addr/len, burst_start<=wr_ptr, ARVALID<=1, go to ADDR.
  - SETPTR or unknown opcode: stay in IDLE. This allows one instruction per cycle.
- **ADDR**
  - On ARREADY: ARVALID<=0, RREADY<=1, go to DATA.
  - ARADDR and ARLEN are held stable while ARVALID=1.
- **DATA**
  - Each beat is a cycle with RVALID & RREADY.
  - On a beat: o_buffer_wr_en=1 (combinational, same cycle), wr_addr=wr_ptr, wr_data=RDATA; then wr_ptr<=wr_ptr+1, wrapping modulo 2^BUFFER_ADDR_WIDTH.
  - On a beat with RRESP[1]=1: err_sticky<=1.
  - On a beat with RLAST: RREADY<=0, go to RESP.
- **RESP** (one cycle)
  - Error on any beat, including the RLAST beat: wr_ptr<=burst_start, ARVALID<=1, err_sticky<=0, go to ADDR. This is a full-burst retry with no retry limit.
  - No error: go to IDLE.
- **Burst length:** 32*(len+1) beats, i.e. 32..256.
- **Latency:** first AR is presented the cycle after the pop. The next instruction can be popped 1 cycle after RESP.
- **RREADY:** never asserted outside DATA. R beats arriving in ADDR are not accepted.
- **Reset mid-burst:** returns to IDLE immediately. Beats already written stay in the buffer. The outstanding AXI transaction is abandoned; the interconnect is reset too.

Optional Feature:
- Macro: LOAD_RLAST_CHECK_EN.
- With the macro:
  - A 9-bit beat counter, cleared at ADDR exit, is compared with ARLEN.
  - RLAST early or late sets o_load_protocol_err (sticky until reset).
  - A missing RLAST forces DATA to end after ARLEN+1 beats; RREADY drops and the FSM goes to RESP.
- Without the macro: no counter, o_load_protocol_err tied 0, the burst ends only on RLAST.

Decomposition:
- Shared package (load/store common):
  - Opcode constants OP_WB, OP_STORE, OP_LOAD, OP_SETPTR.
  - Instruction field position constants.
  - AXI constants: SIZE_4B, BURST_INCR, RESP_SLVERR bit index.
  - State encoding, one-hot 4 bits.
- No sub-module needed; the FSM plus pointer fit in a single module.

Test Plan:
- SETPTR 0x0100, then LOAD len=0 addr=0x40, slave always ready:
  - ARADDR=0x00000100, ARLEN=31.
  - 32 writes to addresses 0x100..0x11F with data matching memory.
  - o_load_idle returns 1.
- LOAD len=7 with random RVALID gaps and ARREADY delayed 5 cycles:
  - ARVALID is held for the 5 cycles.
  - 256 writes, contiguous, with no write in gap cycles.
- SLVERR on beat 10 of a len=0 burst:
  - AR is reissued with the same ARADDR.
  - The second burst rewrites from burst_start, and the final buffer contents are from the retry.
- wr_ptr=0x7FF0 with len=0:
  - Writes cover 0x7FF0..0x7FFF, then 0x0000..0x000F (wrap).
- Back-to-back SETPTR, unknown opcode, LOAD with the FIFO never empty:
  - Three pops in 3 consecutive cycles.
  - AR appears on the 4th cycle.
- With LOAD_RLAST_CHECK_EN, RLAST on beat 20 of a len=0 burst:
  - o_load_protocol_err=1 and the FSM goes to IDLE.
  - Without the macro, the error output stays 0.
